// File: rtl/sodor5_issue_ctrl.sv
// Issue/hazard sequencer for the sodor5 five-stage model: shadows per-slot occupancy and
// destination registers, holds RAW-dependent instructions back with bubbles, counts retires/stalls.
module sodor5_issue_ctrl #(
   parameter int DEPTH      = 5,
   parameter int HAZ_STAGES = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_en,
   input  logic             drain,
   input  logic             imem_valid,
   input  logic [31:0]      imem_data,
   output logic             control_fetch_i,
   output logic             control_shift_iq,
   output logic             imem_ready,
   output logic             hazard,
   output logic [DEPTH-1:0] slot_valid,
   output logic             idle,
   output logic [CNT_W-1:0] retire_count,
   output logic [CNT_W-1:0] stall_count
);

   logic [DEPTH-1:0] r_slot_valid;
   logic [DEPTH-1:0] r_slot_wr;
   logic [4:0]       r_slot_rd [DEPTH];
   logic [CNT_W-1:0] r_retire_count;
   logic [CNT_W-1:0] r_stall_count;

   logic [6:0] w_opcode;
   logic [4:0] w_rd;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic       w_writes;
   logic       w_uses_rs1;
   logic       w_uses_rs2;
   logic       w_hazard;
   logic       w_unused_bits;

   assign w_opcode      = imem_data[6:0];
   assign w_rd          = imem_data[11:7];
   assign w_rs1         = imem_data[19:15];
   assign w_rs2         = imem_data[24:20];
   assign w_unused_bits = ^{imem_data[31:25], imem_data[14:12]};

   always_comb begin
      w_writes   = 1'b0;
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
      case (w_opcode)
         7'b0010011: begin w_writes = 1'b1; w_uses_rs1 = 1'b1; end
         7'b0110011: begin w_writes = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
         7'b0000011: begin w_writes = 1'b1; w_uses_rs1 = 1'b1; end
         7'b0110111: w_writes = 1'b1;
         7'b0010111: w_writes = 1'b1;
         7'b1101111: w_writes = 1'b1;
         7'b1100111: begin w_writes = 1'b1; w_uses_rs1 = 1'b1; end
         7'b0100011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
         7'b1100011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
         default: ;
      endcase
   end

   // x0 is never a real source or destination, so it is excluded on both sides of the compare
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < HAZ_STAGES; i++) begin
         if (r_slot_valid[i] && r_slot_wr[i] && (r_slot_rd[i] != 5'd0) &&
             ((w_uses_rs1 && (w_rs1 == r_slot_rd[i])) ||
              (w_uses_rs2 && (w_rs2 == r_slot_rd[i]))))
            w_hazard = 1'b1;
      end
   end

   assign hazard           = imem_valid & w_hazard;
   assign control_shift_iq = run_en;
   assign control_fetch_i  = run_en & imem_valid & ~drain & ~hazard;
   assign imem_ready       = control_fetch_i;
   assign slot_valid       = r_slot_valid;
   assign idle             = ~|r_slot_valid;
   assign retire_count     = r_retire_count;
   assign stall_count      = r_stall_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_slot_valid <= '0;
         r_slot_wr    <= '0;
         for (int i = 0; i < DEPTH; i++) r_slot_rd[i] <= 5'd0;
      end else if (control_shift_iq) begin
         r_slot_valid <= {r_slot_valid[DEPTH-2:0], control_fetch_i};
         r_slot_wr    <= {r_slot_wr[DEPTH-2:0], control_fetch_i & w_writes & (w_rd != 5'd0)};
         for (int i = DEPTH-1; i > 0; i--) r_slot_rd[i] <= r_slot_rd[i-1];
         r_slot_rd[0] <= control_fetch_i ? w_rd : 5'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retire_count <= '0;
         r_stall_count  <= '0;
      end else begin
         if (control_shift_iq && r_slot_valid[DEPTH-1])
            r_retire_count <= r_retire_count + CNT_W'(1);
         if (run_en && imem_valid && hazard && !drain)
            r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_sodor5_issue_ctrl.sv
// Bench for sodor5_issue_ctrl: directed scenarios then random traffic, all compared against
// an instruction-age reference model of the pipeline.
module tb_sodor5_issue_ctrl;
   localparam int DEPTH = 5;
   localparam int HAZ   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        run_en, drain, imem_valid;
   logic [31:0] imem_data;
   logic        control_fetch_i, control_shift_iq, imem_ready, hazard, idle;
   logic [DEPTH-1:0] slot_valid;
   logic [31:0] retire_count, stall_count;

   sodor5_issue_ctrl dut (
      .clk(clk), .reset(reset), .run_en(run_en), .drain(drain), .imem_valid(imem_valid),
      .imem_data(imem_data), .control_fetch_i(control_fetch_i),
      .control_shift_iq(control_shift_iq), .imem_ready(imem_ready), .hazard(hazard),
      .slot_valid(slot_valid), .idle(idle), .retire_count(retire_count),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {int age; logic [4:0] rd; bit wr;} ent_t;
   ent_t        q[$];
   logic [31:0] m_retire, m_stall;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void decode(input logic [31:0] ins, output bit wr, output bit u1,
                                  output bit u2);
      wr = 0; u1 = 0; u2 = 0;
      case (ins[6:0])
         7'h13, 7'h03, 7'h67: begin wr = 1; u1 = 1; end
         7'h33:               begin wr = 1; u1 = 1; u2 = 1; end
         7'h37, 7'h17, 7'h6f: wr = 1;
         7'h23, 7'h63:        begin u1 = 1; u2 = 1; end
         default: ;
      endcase
   endfunction

   function automatic bit model_hazard(input bit v, input logic [31:0] ins);
      bit wr, u1, u2, h;
      decode(ins, wr, u1, u2);
      h = 0;
      foreach (q[k])
         if (q[k].age < HAZ && q[k].wr && q[k].rd != 0 &&
             ((u1 && ins[19:15] == q[k].rd) || (u2 && ins[24:20] == q[k].rd)))
            h = 1;
      return v && h;
   endfunction

   function automatic logic [DEPTH-1:0] model_slots();
      logic [DEPTH-1:0] s = '0;
      foreach (q[k]) s[q[k].age] = 1'b1;
      return s;
   endfunction

   function automatic void model_clear();
      q.delete();
      m_retire = 0;
      m_stall  = 0;
   endfunction

   // One clock: drive at negedge, check settled outputs, then advance the model for the edge.
   task automatic cycle(input bit run, input bit drn, input bit v, input logic [31:0] ins,
                        output bit fobs);
      bit   h, f, wr, u1, u2;
      ent_t nq[$];
      ent_t e;
      @(negedge clk);
      run_en = run; drain = drn; imem_valid = v; imem_data = ins;
      #1;
      h = model_hazard(v, ins);
      f = run && v && !drn && !h;
      chk("hazard", hazard, h);
      chk("fetch", control_fetch_i, f);
      chk("shift", control_shift_iq, run);
      chk("imem_ready", imem_ready, f);
      chk("slot_valid", slot_valid, model_slots());
      chk("idle", idle, q.size() == 0);
      chk("retire_count", retire_count, m_retire);
      chk("stall_count", stall_count, m_stall);
      fobs = control_fetch_i;
      if (run) begin
         if (v && h && !drn) m_stall++;
         foreach (q[k]) begin
            e = q[k];
            e.age++;
            if (e.age >= DEPTH) m_retire++;
            else nq.push_back(e);
         end
         if (f) begin
            decode(ins, wr, u1, u2);
            e.age = 0; e.rd = ins[11:7]; e.wr = wr;
            nq.push_back(e);
         end
         q = nq;
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      bit f;
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 32'h0, f);
   endtask

   function automatic logic [31:0] rand_ins();
      logic [6:0] op;
      case ($urandom_range(0, 11))
         0: op = 7'h13;  1: op = 7'h33;  2: op = 7'h03;  3: op = 7'h37;
         4: op = 7'h17;  5: op = 7'h6f;  6: op = 7'h67;  7: op = 7'h23;
         8: op = 7'h63;  9: op = 7'h13;  10: op = 7'h33; default: op = 7'h7f;
      endcase
      return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
              5'($urandom_range(0, 3)), op};
   endfunction

   bit          f;
   logic [31:0] r0, s0;

   initial begin
      reset = 1'b0; run_en = 0; drain = 0; imem_valid = 0; imem_data = 32'h0;
      model_clear();
      #1;
      chk("rst_slot_valid", slot_valid, 0);
      chk("rst_idle", idle, 1);
      chk("rst_hazard", hazard, 0);
      chk("rst_retire", retire_count, 0);
      chk("rst_stall", stall_count, 0);
      #11 reset = 1'b1;

      for (int i = 0; i < 10; i++) cycle(1, 0, 0, 32'h0, f);

      cycle(1, 0, 1, 32'h00500093, f); chk("indep_first", f, 1);
      cycle(1, 0, 1, 32'h00300193, f); chk("indep_second", f, 1);
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 32'h0, f);
      settle();
      chk("indep_retired", retire_count, 2);

      s0 = m_stall;
      cycle(1, 0, 1, 32'h00500093, f);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 0, 1, 32'h00108113, f);
         if (i < 4) chk("raw_hold", f, 0);
         else       chk("raw_accept", f, 1);
      end
      settle();
      chk("raw_stalls", stall_count - s0, 4);

      flush();
      cycle(1, 0, 1, 32'h00112023, f);
      cycle(1, 0, 1, 32'h00108113, f); chk("store_no_raw", f, 1);
      cycle(1, 0, 1, 32'h00700013, f);
      cycle(1, 0, 1, 32'h00000113, f); chk("x0_no_raw", f, 1);

      flush();
      cycle(0, 0, 1, 32'h00500093, f); chk("run_off_fetch", f, 0);

      flush();
      cycle(1, 0, 1, 32'h00500093, f);
      cycle(1, 0, 1, 32'h00300193, f);
      cycle(1, 0, 1, 32'h00700213, f);
      r0 = m_retire;
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, 1, 32'h00108113, f);
         chk("drain_fetch", f, 0);
      end
      settle();
      chk("drain_not_idle", idle, 0);
      cycle(1, 1, 1, 32'h00108113, f);
      settle();
      chk("drain_idle", idle, 1);
      chk("drain_retired", retire_count - r0, 3);
      cycle(1, 0, 1, 32'h00108113, f); chk("drain_resume", f, 1);

      flush();
      cycle(1, 0, 1, 32'h00500093, f);
      cycle(1, 0, 1, 32'h00300193, f);
      cycle(1, 0, 1, 32'h00700213, f);
      cycle(1, 0, 1, 32'h00900293, f);
      settle();
      chk("pre_reset_slots", slot_valid, 5'b01111);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_slots", slot_valid, 0);
      chk("mid_rst_retire", retire_count, 0);
      chk("mid_rst_stall", stall_count, 0);
      model_clear();
      #1 reset = 1'b1;
      cycle(1, 0, 1, 32'h00500093, f); chk("post_rst_fetch", f, 1);

      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 3) != 0, rand_ins(), f);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
